// File: rtl/gray_stream_arbiter_if.sv
// Stream bundle around the shared grayscale core:
// two RGB requesters, core forward/return ports, two gray consumers.
interface gray_stream_arbiter_if #(
    parameter int DW = 8
);
    logic [3*DW-1:0] s0_tdata;
    logic            s0_tvalid;
    logic            s0_tlast;
    logic            s0_tready;
    logic [3*DW-1:0] s1_tdata;
    logic            s1_tvalid;
    logic            s1_tlast;
    logic            s1_tready;
    logic [3*DW-1:0] core_tdata;
    logic            core_tvalid;
    logic            core_tready;
    logic [DW-1:0]   core_gray_tdata;
    logic            core_gray_tvalid;
    logic            core_gray_tready;
    logic [DW-1:0]   m0_tdata;
    logic            m0_tvalid;
    logic            m0_tlast;
    logic            m0_tready;
    logic [DW-1:0]   m1_tdata;
    logic            m1_tvalid;
    logic            m1_tlast;
    logic            m1_tready;

    // Arbiter side
    modport slave (
        input  s0_tdata, s0_tvalid, s0_tlast,
        output s0_tready,
        input  s1_tdata, s1_tvalid, s1_tlast,
        output s1_tready,
        output core_tdata, core_tvalid,
        input  core_tready,
        input  core_gray_tdata, core_gray_tvalid,
        output core_gray_tready,
        output m0_tdata, m0_tvalid, m0_tlast,
        input  m0_tready,
        output m1_tdata, m1_tvalid, m1_tlast,
        input  m1_tready
    );

    // Environment side (sources, core, consumers)
    modport master (
        output s0_tdata, s0_tvalid, s0_tlast,
        input  s0_tready,
        output s1_tdata, s1_tvalid, s1_tlast,
        input  s1_tready,
        input  core_tdata, core_tvalid,
        output core_tready,
        output core_gray_tdata, core_gray_tvalid,
        input  core_gray_tready,
        input  m0_tdata, m0_tvalid, m0_tlast,
        output m0_tready,
        input  m1_tdata, m1_tvalid, m1_tlast,
        output m1_tready
    );
endinterface

// File: rtl/gray_stream_arbiter.sv
// Packet-locked round-robin sharing of one grayscale core between two
// RGB requesters; a tag FIFO steers each returning pixel to its owner.
module gray_stream_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int TAG_DEPTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    gray_stream_arbiter_if.slave  bus,
    output logic                  err_orphan
);

    localparam int PW = $clog2(TAG_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(TAG_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          rr_ptr;
    logic          rr_ptr_nxt;

    logic [1:0]    tag_mem [TAG_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          fifo_full;
    logic          fifo_empty;
    logic [1:0]    head;

    logic          push;
    logic          push_id;
    logic          push_last;
    logic          pop;

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    assign head       = tag_mem[rd_ptr];

    assign push    = bus.core_tvalid & bus.core_tready;
    assign push_id = (state == GNT1);
    assign pop     = bus.core_gray_tvalid & bus.core_gray_tready;

    // Grant state and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= 1'b0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    // Grant decision; a grant is released only on the packet's last beat
    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        unique case (state)
            IDLE: begin
                if (bus.s0_tvalid && bus.s1_tvalid)
                    state_nxt = rr_ptr ? GNT1 : GNT0;
                else if (bus.s0_tvalid)
                    state_nxt = GNT0;
                else if (bus.s1_tvalid)
                    state_nxt = GNT1;
            end
            GNT0: begin
                if (bus.s0_tvalid && bus.s0_tready && bus.s0_tlast) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = 1'b1;
                end
            end
            GNT1: begin
                if (bus.s1_tvalid && bus.s1_tready && bus.s1_tlast) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Forward mux from the granted requester into the core
    always_comb begin
        bus.core_tdata  = '0;
        bus.core_tvalid = 1'b0;
        bus.s0_tready   = 1'b0;
        bus.s1_tready   = 1'b0;
        push_last       = 1'b0;
        unique case (state)
            GNT0: begin
                bus.core_tdata  = bus.s0_tdata;
                bus.core_tvalid = bus.s0_tvalid & ~fifo_full;
                bus.s0_tready   = bus.core_tready & ~fifo_full;
                push_last       = bus.s0_tlast;
            end
            GNT1: begin
                bus.core_tdata  = bus.s1_tdata;
                bus.core_tvalid = bus.s1_tvalid & ~fifo_full;
                bus.s1_tready   = bus.core_tready & ~fifo_full;
                push_last       = bus.s1_tlast;
            end
            default: ;
        endcase
    end

    // Tag storage; contents are don't-care while the slot is unoccupied
    always_ff @(posedge clk) begin
        if (push)
            tag_mem[wr_ptr] <= {push_id, push_last};
    end

    // Tag FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Return routing by head tag; nothing is accepted without a tag
    always_comb begin
        bus.m0_tdata         = bus.core_gray_tdata;
        bus.m1_tdata         = bus.core_gray_tdata;
        bus.m0_tvalid        = 1'b0;
        bus.m1_tvalid        = 1'b0;
        bus.m0_tlast         = 1'b0;
        bus.m1_tlast         = 1'b0;
        bus.core_gray_tready = 1'b0;
        if (!fifo_empty) begin
            if (head[1]) begin
                bus.m1_tvalid        = bus.core_gray_tvalid;
                bus.m1_tlast         = head[0];
                bus.core_gray_tready = bus.m1_tready;
            end else begin
                bus.m0_tvalid        = bus.core_gray_tvalid;
                bus.m0_tlast         = head[0];
                bus.core_gray_tready = bus.m0_tready;
            end
        end
    end

    // Sticky flag for a core output with no matching tag
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_orphan <= 1'b0;
        else if (bus.core_gray_tvalid && fifo_empty)
            err_orphan <= 1'b1;
    end

endmodule

// File: tb/tb_gray_stream_arbiter.sv
// Directed bench: two scripted RGB sources, a behavioural gray core
// and two logging consumers around gray_stream_arbiter.
module tb_gray_stream_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic err_orphan;

    gray_stream_arbiter_if #(.DW(8)) bus ();

    gray_stream_arbiter #(
        .DATA_WIDTH(8),
        .TAG_DEPTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scripted sources
    logic [23:0] s0_pix [32];
    logic        s0_lst [32];
    logic [23:0] s1_pix [32];
    logic        s1_lst [32];
    int s0_n = 0, s1_n = 0;
    int s0_ptr, s1_ptr;

    always @* begin
        bus.s0_tvalid = (s0_ptr < s0_n);
        bus.s0_tdata  = (s0_ptr < s0_n) ? s0_pix[s0_ptr] : 24'h0;
        bus.s0_tlast  = (s0_ptr < s0_n) ? s0_lst[s0_ptr] : 1'b0;
        bus.s1_tvalid = (s1_ptr < s1_n);
        bus.s1_tdata  = (s1_ptr < s1_n) ? s1_pix[s1_ptr] : 24'h0;
        bus.s1_tlast  = (s1_ptr < s1_n) ? s1_lst[s1_ptr] : 1'b0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_ptr <= 0;
            s1_ptr <= 0;
        end else begin
            if (bus.s0_tvalid && bus.s0_tready) s0_ptr <= s0_ptr + 1;
            if (bus.s1_tvalid && bus.s1_tready) s1_ptr <= s1_ptr + 1;
        end
    end

    // Behavioural core: Y = (77R + 150G + 29B) >> 8, in-order queue
    function automatic logic [7:0] gray_of(input logic [23:0] p);
        int y;
        y = (77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0])) >> 8;
        return y[7:0];
    endfunction

    logic [7:0] cq [64];
    int  cwr, crd;
    bit  inject   = 1'b0;
    logic core_rdy = 1'b1;

    always @* begin
        bus.core_tready      = core_rdy;
        bus.core_gray_tvalid = (cwr != crd) || inject;
        bus.core_gray_tdata  = (cwr != crd) ? cq[crd % 64] : 8'h00;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cwr <= 0;
            crd <= 0;
        end else begin
            if (bus.core_tvalid && bus.core_tready) begin
                cq[cwr % 64] <= gray_of(bus.core_tdata);
                cwr <= cwr + 1;
            end
            if (bus.core_gray_tvalid && bus.core_gray_tready && cwr != crd)
                crd <= crd + 1;
        end
    end

    // Consumer logs
    logic [7:0] l0_d [64];
    logic       l0_l [64];
    int         l0_c [64];
    logic [7:0] l1_d [64];
    logic       l1_l [64];
    int         l1_c [64];
    int l0_n, l1_n;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            l0_n <= 0;
            l1_n <= 0;
        end else begin
            if (bus.m0_tvalid && bus.m0_tready) begin
                l0_d[l0_n] <= bus.m0_tdata;
                l0_l[l0_n] <= bus.m0_tlast;
                l0_c[l0_n] <= cyc;
                l0_n <= l0_n + 1;
            end
            if (bus.m1_tvalid && bus.m1_tready) begin
                l1_d[l1_n] <= bus.m1_tdata;
                l1_l[l1_n] <= bus.m1_tlast;
                l1_c[l1_n] <= cyc;
                l1_n <= l1_n + 1;
            end
        end
    end

    task automatic do_reset();
        s0_n = 0;
        s1_n = 0;
        inject = 1'b0;
        core_rdy = 1'b1;
        bus.m0_tready = 1'b1;
        bus.m1_tready = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_logs(input int t0, input int t1, input int budget,
                             input string tag);
        for (int k = 0; k < budget; k++) begin
            if (l0_n >= t0 && l1_n >= t1) break;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk({tag, "_m0_cnt"}, l0_n, t0);
        chk({tag, "_m1_cnt"}, l1_n, t1);
    endtask

    logic [23:0] bp_pix [12];
    logic [7:0]  bp_exp [12];
    int bad, nlast;
    logic [3:0] mask0;
    logic [5:0] mask1;

    initial begin
        bp_pix = '{24'hFF0000, 24'hC80000, 24'h640000, 24'h320000,
                   24'h0A0000, 24'h800000, 24'h400000, 24'h200000,
                   24'h100000, 24'h080000, 24'h040000, 24'h020000};
        bp_exp = '{8'd76, 8'd60, 8'd30, 8'd15, 8'd3, 8'd38,
                   8'd19, 8'd9, 8'd4, 8'd2, 8'd1, 8'd0};

        // Reset state
        bus.m0_tready = 1'b1;
        bus.m1_tready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_state", 32'(dut.state), 0);
        chk("rst_rr", 32'(dut.rr_ptr), 0);
        chk("rst_count", 32'(dut.count), 0);
        chk("rst_err", 32'(err_orphan), 0);
        chk("rst_valids", {bus.core_tvalid, bus.m0_tvalid, bus.m1_tvalid}, 0);
        chk("rst_readies", {bus.s0_tready, bus.s1_tready,
                            bus.core_gray_tready}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single red pixel
        s0_pix[0] = 24'hFF0000;
        s0_lst[0] = 1'b1;
        s0_n = 1;
        wait_logs(1, 0, 30, "t1");
        chk("t1_data", l0_d[0], 76);
        chk("t1_last", l0_l[0], 1);
        chk("t1_rr", 32'(dut.rr_ptr), 1);

        // Both requesters with 4-pixel packets
        do_reset();
        for (int i = 0; i < 4; i++) begin
            s0_pix[i] = 24'hFF0000;
            s0_lst[i] = (i == 3);
            s1_pix[i] = 24'h00FF00;
            s1_lst[i] = (i == 3);
        end
        s0_n = 4;
        s1_n = 4;
        wait_logs(4, 4, 60, "t2");
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (l0_d[i] != 8'd76)  bad++;
            if (l1_d[i] != 8'd149) bad++;
        end
        chk("t2_data_bad", bad, 0);
        chk("t2_last0", {l0_l[3], l0_l[2], l0_l[1], l0_l[0]}, 4'b1000);
        chk("t2_last1", {l1_l[3], l1_l[2], l1_l[1], l1_l[0]}, 4'b1000);
        chk("t2_s0_first", 32'(l0_c[3] < l1_c[0]), 1);
        chk("t2_rr", 32'(dut.rr_ptr), 0);
        chk("t2_idle", 32'(dut.state), 0);

        // Backpressure fills the tag FIFO
        do_reset();
        bus.m0_tready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            s0_pix[i] = bp_pix[i];
            s0_lst[i] = (i == 11);
        end
        s0_n = 12;
        repeat (30) @(negedge clk);
        chk("t3_accepted", s0_ptr, 8);
        chk("t3_s0_tready", 32'(bus.s0_tready), 0);
        chk("t3_count", 32'(dut.count), 8);
        chk("t3_no_out", l0_n, 0);
        bus.m0_tready = 1'b1;
        wait_logs(12, 0, 60, "t3");
        bad = 0;
        nlast = 0;
        for (int i = 0; i < 12; i++) begin
            if (l0_d[i] != bp_exp[i]) bad++;
            if (l0_l[i]) nlast++;
        end
        chk("t3_order_bad", bad, 0);
        chk("t3_nlast", nlast, 1);
        chk("t3_last_pos", 32'(l0_l[11]), 1);
        chk("t3_issued", s0_ptr, 12);

        // Interleaved packets: two on s0, two on s1
        do_reset();
        for (int i = 0; i < 4; i++) begin
            s0_pix[i] = 24'h0000FF;
            s0_lst[i] = (i == 1) || (i == 3);
        end
        for (int i = 0; i < 6; i++) begin
            s1_pix[i] = 24'h646464;
            s1_lst[i] = (i == 2) || (i == 5);
        end
        s0_n = 4;
        s1_n = 6;
        wait_logs(4, 6, 80, "t4");
        bad = 0;
        for (int i = 0; i < 4; i++) if (l0_d[i] != 8'd28)  bad++;
        for (int i = 0; i < 6; i++) if (l1_d[i] != 8'd100) bad++;
        chk("t4_data_bad", bad, 0);
        for (int i = 0; i < 4; i++) mask0[i] = l0_l[i];
        for (int i = 0; i < 6; i++) mask1[i] = l1_l[i];
        chk("t4_last0", mask0, 4'b1010);
        chk("t4_last1", mask1, 6'b100100);

        // Orphan return with an empty tag FIFO
        do_reset();
        inject = 1'b1;
        #1;
        chk("t5_m0_valid", 32'(bus.m0_tvalid), 0);
        chk("t5_m1_valid", 32'(bus.m1_tvalid), 0);
        chk("t5_gray_rdy", 32'(bus.core_gray_tready), 0);
        chk("t5_err_pre", 32'(err_orphan), 0);
        @(negedge clk);
        inject = 1'b0;
        chk("t5_err", 32'(err_orphan), 1);
        @(negedge clk);
        chk("t5_err_sticky", 32'(err_orphan), 1);
        chk("t5_no_out", l0_n + l1_n, 0);

        // Reset with three tags outstanding
        do_reset();
        bus.m0_tready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s0_pix[i] = 24'hFF0000;
            s0_lst[i] = (i == 5);
        end
        s0_n = 6;
        for (int k = 0; k < 20; k++) begin
            if (dut.count == 3) break;
            @(negedge clk);
        end
        chk("t6_tags3", 32'(dut.count), 3);
        rst = 1'b1;
        s0_n = 0;
        @(negedge clk);
        chk("t6_state", 32'(dut.state), 0);
        chk("t6_count", 32'(dut.count), 0);
        chk("t6_valids", {bus.core_tvalid, bus.m0_tvalid, bus.m1_tvalid}, 0);
        chk("t6_s0_tready", 32'(bus.s0_tready), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
